key_schedule: RTL
=================

KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have no parameters; AES-128 only; widths come from the shared package.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n_i  input  1  reset is asynchronous and active-low.
REQ-004 key_i  input  128  cipher key; word w0 = key_i[127:96] (FIPS-197 byte order, first byte in MSB).
REQ-005 key_v_i  input  1  key_i valid.
REQ-006 key_ready_o  output  1  block can accept a key.
REQ-007 rk_o  output  128  current round key, directly consumable as the key operand of the downstream add-round-key stage.
REQ-008 rk_round_o  output  4  round index of rk_o, 0..10.
REQ-009 rk_v_o  output  1  rk_o/rk_round_o valid.
REQ-010 rk_ready_i  input  1  consumer accepts rk_o.
REQ-011 busy_o  output  1  schedule in progress, i.e. state EMIT.

Function
REQ-012 SHALL implement FSM states IDLE and EMIT.
REQ-013 IDLE: key_ready_o=1, rk_v_o=0.
REQ-014 On key_v_i&key_ready_o: latch key_i into the round-key register, set round=0, go EMIT.
REQ-015 rk_v_o SHALL rise the cycle after key acceptance, with rk_o=key_i and rk_round_o=0.
REQ-016 EMIT: key_ready_o=0; key_v_i SHALL be ignored.
REQ-017 EMIT: rk_v_o=1 continuously.
REQ-018 EMIT with rk_ready_i=0: rk_o and rk_round_o SHALL hold stable.
REQ-019 EMIT handshake (rk_v_o&rk_ready_i) with round<10: the register SHALL load the next round key and round SHALL increment, both effective the following cycle.
REQ-020 Handshake at round==10: go IDLE; rk_v_o=0 the next cycle; rk_o and rk_round_o hold their last values.
REQ-021 Next-key computation: t = SubWord(RotWord(w3)) ^ {Rcon[round+1],24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-022 Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
REQ-023 Next-key computation SHALL be one cycle, combinational from the current register.
REQ-024 Throughput: 11 round keys in 11 cycles under continuous ready; a new key is acceptable the cycle after the round-10 handshake.
REQ-025 key_ready_o and rk_v_o SHALL be pure functions of registered state, never combinational from key_v_i or rk_ready_i.
REQ-026 No output SHALL ever be X after reset.

Reset
REQ-027 Assertion SHALL immediately force: state IDLE, rk_o=0, rk_round_o=0, rk_v_o=0, busy_o=0.
REQ-028 After reset, key_ready_o=1.
REQ-029 Reset mid-EMIT SHALL abort the schedule with no further round keys emitted.
REQ-030 Reset deassertion SHALL be synchronised externally; the block SHALL need no reset-release cycles.

Structure
REQ-031 Shared package aes_pkg SHALL hold: AES_BLOCK_W=128, AES_WORD_W=32, AES_ROUNDS=10, the Rcon table, and the FSM state enum typedef.
REQ-032 SHALL instantiate sub-module aes_sbox (8-bit combinational S-box, reusable by the sub-bytes stage) four times for SubWord.
REQ-033 The FSM, round counter and key register SHALL live in key_schedule.

Verification
REQ-034 Key 000102030405060708090a0b0c0d0e0f, rk_ready_i=1 -> rounds 0..10 on 11 consecutive cycles; round1=d6aa74fdd2af72fadaa678f1d6ab76fe; round10=13111d7fe3944a17f307a78b4d2b30c5.
REQ-035 Key 2b7e151628aed2a6abf7158809cf4f3c -> round1=a0fafe1788542cb123a339392a6c7605; round10=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-036 rk_ready_i toggled pseudo-randomly -> identical 11-key sequence, no key skipped or repeated, rk_o stable whenever stalled.
REQ-037 key_v_i held high through EMIT with a different key_i -> ignored; second key accepted only after round 10; both sequences correct back-to-back.
REQ-038 reset_n_i pulsed low at round 5 -> outputs zero asynchronously, rk_v_o=0, key_ready_o=1; next key yields a clean schedule starting at round 0.
REQ-039 Checker SHALL compare every handshake against a reference key-expansion model.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 shared widths, round constants, key-schedule state type and GF(2^8) helpers.
// Pure declarations: no latency, no flow control.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_ROUNDS  = 10;

    typedef logic [AES_BLOCK_W-1:0] block_t;
    typedef logic [AES_WORD_W-1:0]  word_t;

    // Rcon[1] sits in the least significant byte.
    localparam logic [AES_ROUNDS*8-1:0] RCON_TABLE = 80'h36_1b_80_40_20_10_08_04_02_01;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ks_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'(AES_ROUNDS)) begin
            return RCON_TABLE[(int'(r) - 1) * 8 +: 8];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational: multiplicative inverse followed by the affine map.
// Zero latency, no flow control.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
    always_comb begin
        sq  = in_i;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/key_schedule.sv
// AES-128 key expansion: round keys 0..10 emitted one per accepted handshake, first one the cycle after key acceptance.
// Holds rk_o while rk_ready_i is low; no new key is taken until round 10 has been handed off.
module key_schedule
    import aes_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [AES_BLOCK_W-1:0] key_i,
    input  logic                   key_v_i,
    output logic                   key_ready_o,
    output logic [AES_BLOCK_W-1:0] rk_o,
    output logic [3:0]             rk_round_o,
    output logic                   rk_v_o,
    input  logic                   rk_ready_i,
    output logic                   busy_o
);

    ks_state_t state_q, state_d;
    block_t    rk_q, rk_d;
    logic [3:0] round_q, round_d;

    word_t w0, w1, w2, w3;
    word_t rot_w3, sub_w3, t_w;
    word_t n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_q;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (rot_w3[8*b +: 8]),
            .out_o (sub_w3[8*b +: 8])
        );
    end

    assign t_w = sub_w3 ^ {rcon(4'(round_q + 4'd1)), 24'h000000};
    assign n0  = w0 ^ t_w;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (key_v_i) begin
                    rk_d    = key_i;
                    round_d = 4'd0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (rk_ready_i) begin
                    // Final round leaves the register and index untouched for the consumer.
                    if (round_q == 4'(AES_ROUNDS)) begin
                        state_d = ST_IDLE;
                    end else begin
                        rk_d    = {n0, n1, n2, n3};
                        round_d = round_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
        end
    end

    assign key_ready_o = (state_q == ST_IDLE);
    assign rk_v_o      = (state_q == ST_EMIT);
    assign busy_o      = (state_q == ST_EMIT);
    assign rk_o        = rk_q;
    assign rk_round_o  = round_q;

endmodule
